// File: rtl/step_sequencer_if.sv
// -----------------------------------------------------------------------------
// step_sequencer_if
// Bundles the instruction-sequencer control bus: decoded-instruction and
// memory handshake inputs toward the sequencer, and the control strobes and
// status it produces.
//
// Parameters:
//   D              width of branch_target / target
// Signals (direction as seen by the sequencer, modport slave):
//   start          in   begin execution (used in IDLE only)
//   is_mem         in   decoded instruction needs data memory
//   is_branch      in   decoded instruction is a branch
//   branch_cond    in   ALU branch condition
//   is_halt        in   decoded halt instruction
//   branch_target  in   absolute branch destination [D-1:0]
//   mem_ack        in   data memory completion
//   ir_load        out  instruction-register load strobe
//   mem_req        out  data memory request (level)
//   reg_we         out  register-file write strobe
//   pc_step        out  one-cycle PC update strobe
//   branch_flag    out  with pc_step: load target instead of incrementing
//   target         out  registered jump destination [D-1:0]
//   state          out  current state encoding [2:0]
//   done           out  high in HALT
//   err            out  sticky memory-timeout flag
//   instr_count    out  retired-instruction counter [15:0]
// -----------------------------------------------------------------------------
interface step_sequencer_if #(
  parameter int D = 12
);
  logic         start;
  logic         is_mem;
  logic         is_branch;
  logic         branch_cond;
  logic         is_halt;
  logic [D-1:0] branch_target;
  logic         mem_ack;

  logic         ir_load;
  logic         mem_req;
  logic         reg_we;
  logic         pc_step;
  logic         branch_flag;
  logic [D-1:0] target;
  logic [2:0]   state;
  logic         done;
  logic         err;
  logic [15:0]  instr_count;

  // Side that drives decode/handshake inputs and consumes the strobes.
  modport master (
    output start, is_mem, is_branch, branch_cond, is_halt, branch_target, mem_ack,
    input  ir_load, mem_req, reg_we, pc_step, branch_flag, target, state,
           done, err, instr_count
  );

  // The sequencer itself.
  modport slave (
    input  start, is_mem, is_branch, branch_cond, is_halt, branch_target, mem_ack,
    output ir_load, mem_req, reg_we, pc_step, branch_flag, target, state,
           done, err, instr_count
  );
endinterface

// File: rtl/step_sequencer.sv
// -----------------------------------------------------------------------------
// step_sequencer
// Multi-cycle instruction sequencer: IDLE -> FETCH -> DECODE -> EXEC ->
// [MEM] -> WB -> FETCH ..., with HALT as a terminal state left only by reset.
// Memory accesses wait for mem_ack up to MEM_TO cycles, after which the
// sticky err flag is set and the instruction retires anyway.
//
// Parameters:
//   D       program-counter / branch-target width
//   MEM_TO  maximum MEM cycles before timeout (1..255)
// Ports:
//   clk     clock, all state changes on the rising edge
//   reset   synchronous, active-high reset
//   bus     step_sequencer_if.slave (decode inputs, memory handshake,
//           control strobes and status)
// -----------------------------------------------------------------------------
module step_sequencer #(
  parameter int D      = 12,
  parameter int MEM_TO = 15
) (
  input  logic            clk,
  input  logic            reset,
  step_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXEC    = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_HALT    = 3'd6,
    S_ILLEGAL = 3'd7
  } state_t;

  localparam logic [7:0]  MEM_TO_C  = 8'(MEM_TO);
  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  state_t       state_q, state_d;
  logic         mem_flag_q, mem_flag_d;   // DECODE saw a memory instruction
  logic         br_flag_q, br_flag_d;     // DECODE saw a branch
  logic         taken_q, taken_d;         // EXEC resolved the branch as taken
  logic         err_q, err_d;
  logic [D-1:0] target_q, target_d;
  logic [7:0]   mem_cnt_q, mem_cnt_d;     // MEM cycles already spent
  logic [15:0]  instr_count_q, instr_count_d;
  logic [7:0]   mem_cnt_inc;

  assign mem_cnt_inc = mem_cnt_q + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      mem_flag_q    <= 1'b0;
      br_flag_q     <= 1'b0;
      taken_q       <= 1'b0;
      err_q         <= 1'b0;
      target_q      <= '0;
      mem_cnt_q     <= '0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      mem_flag_q    <= mem_flag_d;
      br_flag_q     <= br_flag_d;
      taken_q       <= taken_d;
      err_q         <= err_d;
      target_q      <= target_d;
      mem_cnt_q     <= mem_cnt_d;
      instr_count_q <= instr_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    mem_flag_d    = mem_flag_q;
    br_flag_d     = br_flag_q;
    taken_d       = taken_q;
    err_d         = err_q;
    target_d      = target_q;
    mem_cnt_d     = mem_cnt_q;
    instr_count_d = instr_count_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_FETCH;
      end

      S_FETCH: begin
        state_d = S_DECODE;
      end

      S_DECODE: begin
        mem_flag_d = bus.is_mem;
        br_flag_d  = bus.is_branch;
        if (bus.is_halt) state_d = S_HALT;
        else             state_d = S_EXEC;
      end

      S_EXEC: begin
        // Clearing here means the counter starts at zero on MEM entry.
        mem_cnt_d = '0;
        taken_d   = br_flag_q & bus.branch_cond;
        if (br_flag_q && bus.branch_cond) target_d = bus.branch_target;
        state_d = mem_flag_q ? S_MEM : S_WB;
      end

      S_MEM: begin
        mem_cnt_d = mem_cnt_inc;
        // An ack on the limit cycle wins over the timeout.
        if (bus.mem_ack) begin
          state_d = S_WB;
        end else if (mem_cnt_inc == MEM_TO_C) begin
          err_d   = 1'b1;
          state_d = S_WB;
        end
      end

      S_WB: begin
        if (instr_count_q != COUNT_MAX) instr_count_d = instr_count_q + 16'd1;
        state_d = S_FETCH;
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        // Unreachable encoding: recover to IDLE.
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes are decoded from the registered state only, so each lasts one
  // cycle per visit to its state.
  assign bus.ir_load     = (state_q == S_FETCH);
  assign bus.mem_req     = (state_q == S_MEM);
  assign bus.reg_we      = (state_q == S_WB) & ~taken_q;
  assign bus.pc_step     = (state_q == S_WB);
  assign bus.branch_flag = (state_q == S_WB) & taken_q;
  assign bus.done        = (state_q == S_HALT);
  assign bus.target      = target_q;
  assign bus.state       = state_q;
  assign bus.err         = err_q;
  assign bus.instr_count = instr_count_q;

endmodule

// File: tb/tb_step_sequencer.sv
// -----------------------------------------------------------------------------
// tb_step_sequencer
// Self-checking bench for step_sequencer: a table of hand-computed
// instructions, directed halt / reset / saturation sequences, and a random
// instruction stream checked against an instruction-level model.
// -----------------------------------------------------------------------------
module tb_step_sequencer;
  localparam int D      = 12;
  localparam int MEM_TO = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  step_sequencer_if #(.D(D)) bus ();

  step_sequencer #(.D(D), .MEM_TO(MEM_TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit           mem;
    bit           br;
    bit           cond;
    logic [D-1:0] tgt;
    int           ack;      // MEM cycle index carrying mem_ack, -1 = never
    int           cyc;      // expected cycles from FETCH to WB inclusive
    bit           we;       // expected reg_we pulses
    bit           bf;       // expected branch_flag pulses
    int           mreq;     // expected mem_req cycles
    logic [D-1:0] tgt_exp;
    bit           err;
    int           count;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // instruction-level model state
  int           m_count;
  logic [D-1:0] m_target;
  bit           m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, " state"}, 32'(bus.state), 32'd0);
    chk({tag, " strobes"},
        32'({bus.ir_load, bus.mem_req, bus.reg_we, bus.pc_step, bus.branch_flag, bus.done}),
        32'd0);
    chk({tag, " err"}, 32'(bus.err), 32'd0);
    chk({tag, " target"}, 32'(bus.target), 32'd0);
    chk({tag, " instr_count"}, 32'(bus.instr_count), 32'd0);
  endtask

  // Reset asserted with start and mem_ack also high: reset must win.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.start = 1'b1;
    bus.mem_ack = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.start = 1'b0;
    bus.mem_ack = 1'b0;
    chk_zero("reset");
    $display("reset: state=%0d count=%0d", bus.state, bus.instr_count);
    m_count = 0; m_target = '0; m_err = 0;
  endtask

  // From IDLE: idle a couple of cycles, then pulse start; ends in FETCH.
  task automatic do_start();
    for (int i = 0; i < 2; i++) @(negedge clk);
    chk("idle hold", 32'(bus.state), 32'd0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("start->fetch", 32'(bus.state), 32'd1);
  endtask

  // Called at a negedge with the DUT in FETCH; returns at the negedge of the
  // following FETCH. Inputs outside their sampling state are randomised.
  task automatic run_instr(input vec_t v, input string tag);
    int n_ir, n_mreq, n_we, n_pc, n_bf, pc_at;
    n_ir = 0; n_mreq = 0; n_we = 0; n_pc = 0; n_bf = 0; pc_at = 0;
    for (int c = 1; c <= v.cyc; c++) begin
      if (c > 1) @(negedge clk);
      if (bus.ir_load)     n_ir++;
      if (bus.mem_req)     n_mreq++;
      if (bus.reg_we)      n_we++;
      if (bus.pc_step)     begin n_pc++; pc_at = c; end
      if (bus.branch_flag) n_bf++;
      bus.start         = rbit();
      bus.is_halt       = (c == 2) ? 1'b0   : rbit();
      bus.is_mem        = (c == 2) ? v.mem  : rbit();
      bus.is_branch     = (c == 2) ? v.br   : rbit();
      bus.branch_cond   = (c == 3) ? v.cond : rbit();
      bus.branch_target = (c == 3) ? v.tgt  : D'($urandom);
      if (v.mem && c >= 4 && c < 4 + v.mreq) bus.mem_ack = (c - 4 == v.ack);
      else                                   bus.mem_ack = rbit();
    end
    @(negedge clk);
    chk({tag, " ir_load pulses"}, 32'(n_ir), 32'd1);
    chk({tag, " pc_step pulses"}, 32'(n_pc), 32'd1);
    chk({tag, " pc_step cycle"}, 32'(pc_at), 32'(v.cyc));
    chk({tag, " reg_we pulses"}, 32'(n_we), 32'(v.we));
    chk({tag, " branch_flag pulses"}, 32'(n_bf), 32'(v.bf));
    chk({tag, " mem_req cycles"}, 32'(n_mreq), 32'(v.mreq));
    chk({tag, " target"}, 32'(bus.target), 32'(v.tgt_exp));
    chk({tag, " err"}, 32'(bus.err), 32'(v.err));
    chk({tag, " instr_count"}, 32'(bus.instr_count), 32'(v.count));
    chk({tag, " back to fetch"}, 32'(bus.state), 32'd1);
    $display("%s: mem=%0d br=%0d cond=%0d ack=%0d cyc=%0d mreq=%0d target=%h err=%0d count=%0d",
             tag, v.mem, v.br, v.cond, v.ack, pc_at, n_mreq, bus.target, bus.err, bus.instr_count);
  endtask

  // Builds expectations for one instruction from the instruction-level rules.
  function automatic vec_t model_instr(input bit mem, input bit br, input bit cond,
                                       input logic [D-1:0] tgt, input int ack);
    vec_t v;
    bit acked, taken;
    int mcyc;
    acked = (ack >= 0) && (ack < MEM_TO);
    taken = br && cond;
    mcyc  = mem ? (acked ? ack + 1 : MEM_TO) : 0;
    if (mem && !acked) m_err = 1;
    if (taken) m_target = tgt;
    m_count = (m_count >= 65535) ? 65535 : m_count + 1;
    v = '{mem, br, cond, tgt, ack, 4 + mcyc, !taken, taken, mcyc, m_target, m_err, m_count};
    return v;
  endfunction

  task automatic run_halt(input int count_exp);
    int viol;
    viol = 0;
    bus.is_halt = 1'b0;
    @(negedge clk);                       // DECODE
    bus.is_halt   = 1'b1;
    bus.is_mem    = rbit();
    bus.is_branch = rbit();
    @(negedge clk);
    chk("halt state", 32'(bus.state), 32'd6);
    chk("halt done", 32'(bus.done), 32'd1);
    for (int i = 0; i < 20; i++) begin
      bus.start   = 1'b1;
      bus.is_halt = rbit();
      bus.mem_ack = rbit();
      @(negedge clk);
      if (bus.state != 3'd6 || !bus.done || bus.pc_step || bus.ir_load ||
          bus.reg_we || bus.mem_req) viol++;
    end
    bus.start = 1'b0;
    chk("halt hold violations", 32'(viol), 32'd0);
    chk("halt not counted", 32'(bus.instr_count), 32'(count_exp));
    $display("halt: state=%0d done=%0d count=%0d", bus.state, bus.done, bus.instr_count);
  endtask

  vec_t tbl [11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    reset = 1'b1;
    bus.start = 1'b0; bus.is_mem = 1'b0; bus.is_branch = 1'b0; bus.branch_cond = 1'b0;
    bus.is_halt = 1'b0; bus.branch_target = '0; bus.mem_ack = 1'b0;

    //           mem br cond tgt      ack cyc we bf mreq tgt_exp  err count
    tbl[0]  = '{0, 0, 0, 12'h000, -1,  4, 1, 0, 0,  12'h000, 0, 1};
    tbl[1]  = '{0, 0, 1, 12'h7FF, -1,  4, 1, 0, 0,  12'h000, 0, 2};
    tbl[2]  = '{0, 0, 0, 12'h000, -1,  4, 1, 0, 0,  12'h000, 0, 3};
    tbl[3]  = '{0, 1, 1, 12'h0A5, -1,  4, 0, 1, 0,  12'h0A5, 0, 4};
    tbl[4]  = '{0, 1, 0, 12'h123, -1,  4, 1, 0, 0,  12'h0A5, 0, 5};
    tbl[5]  = '{1, 0, 0, 12'h000,  0,  5, 1, 0, 1,  12'h0A5, 0, 6};
    tbl[6]  = '{1, 0, 0, 12'h000,  3,  8, 1, 0, 4,  12'h0A5, 0, 7};
    tbl[7]  = '{1, 0, 0, 12'h000, 14, 19, 1, 0, 15, 12'h0A5, 0, 8};
    tbl[8]  = '{1, 1, 1, 12'h03C,  1,  6, 0, 1, 2,  12'h03C, 0, 9};
    tbl[9]  = '{1, 0, 0, 12'h000, -1, 19, 1, 0, 15, 12'h03C, 1, 10};
    tbl[10] = '{0, 0, 0, 12'h000, -1,  4, 1, 0, 0,  12'h03C, 1, 11};

    do_reset();
    do_start();
    for (int i = 0; i < 11; i++) run_instr(tbl[i], $sformatf("tbl%0d", i));

    run_halt(11);

    // Reset in the middle of a memory wait, with count/target/err non-zero.
    do_reset();
    do_start();
    run_instr(model_instr(1'b0, 1'b1, 1'b1, 12'h05A, -1), "pre_a");
    run_instr(model_instr(1'b1, 1'b0, 1'b0, 12'h000, -1), "pre_b");
    bus.is_mem = 1'b0;
    @(negedge clk);                       // DECODE
    bus.is_mem = 1'b1; bus.is_halt = 1'b0; bus.is_branch = 1'b0;
    @(negedge clk);                       // EXEC
    bus.mem_ack = 1'b0;
    @(negedge clk);                       // MEM cycle 1
    chk("mid-mem mem_req", 32'(bus.mem_req), 32'd1);
    @(negedge clk);                       // MEM cycle 2
    do_reset();

    // Random instruction stream against the model.
    do_start();
    for (int i = 0; i < 40; i++) begin
      int ack;
      ack = int'($urandom_range(0, 19));
      if (ack == 19) ack = -1;
      v = model_instr(rbit(), rbit(), rbit(), D'($urandom), ack);
      run_instr(v, $sformatf("rnd%0d", i));
    end

    // Saturation: preload the counter near its limit, then retire three.
    do_reset();
    force dut.instr_count_q = 16'hFFFE;
    @(negedge clk);
    release dut.instr_count_q;
    @(negedge clk);
    chk("preload", 32'(bus.instr_count), 32'hFFFE);
    m_count = 16'hFFFE;
    do_start();
    for (int i = 0; i < 3; i++)
      run_instr(model_instr(1'b0, 1'b0, 1'b0, 12'h000, -1), $sformatf("sat%0d", i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
